// File: rtl/ntt_bf_pe_if.sv
// Stream bus of the butterfly PE: one operand set in, one result pair out per cycle.
interface ntt_bf_pe_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  valid_in;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] u;
  logic [DATA_WIDTH-1:0] v;
  logic [DATA_WIDTH-1:0] w;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] bf_upper;
  logic [DATA_WIDTH-1:0] bf_lower;

  modport master (
    output valid_in, mode, u, v, w,
    input  valid_out, bf_upper, bf_lower
  );

  modport slave (
    input  valid_in, mode, u, v, w,
    output valid_out, bf_upper, bf_lower
  );
endinterface

// File: rtl/ntt_bf_pe.sv
// Four-stage modular butterfly (add/sub, CT, GS) with Barrett reduction.
// Optional macro NTT_BF_HALF_EN: GS outputs are multiplied by 2^-1 mod Q in S4.
module ntt_bf_pe #(
  parameter int          DATA_WIDTH = 12,
  parameter int          MODULUS    = 3329,
  parameter int unsigned BARRETT_M  = int'((64'd1 << (2 * DATA_WIDTH)) / 64'(MODULUS))
) (
  input  logic        clk,
  input  logic        rst,
  ntt_bf_pe_if.slave  bus
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int MW = $clog2(BARRETT_M + 1);

  localparam logic [DW:0]        Q_1 = (DW + 1)'(MODULUS);
  localparam logic [DW+1:0]      Q_2 = (DW + 2)'(MODULUS);
  localparam logic [PW+MW-1:0]   BM  = (PW + MW)'(BARRETT_M);

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_CT   = 2'b01,
    MODE_GS   = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= Q_1) s = s - Q_1;
    return s[DW-1:0];
  endfunction

  // A borrow out of the (DW+1)-bit difference marks a negative result.
  function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0] s;
    s = {1'b0, x} - {1'b0, y};
    if (s[DW]) s = s + Q_1;
    return s[DW-1:0];
  endfunction

  // q_est undershoots the true quotient by at most 2, so r < 3Q fits in DW+2 bits.
  function automatic logic [DW-1:0] barrett(input logic [PW-1:0] a);
    logic [PW+MW-1:0] am;
    logic [DW+1:0]    q_lo;
    logic [DW+1:0]    r;
    am   = (PW + MW)'(a) * BM;
    q_lo = (DW + 2)'(am >> PW);
    r    = a[DW+1:0] - q_lo * Q_2;
    if (r >= Q_2) r = r - Q_2;
    if (r >= Q_2) r = r - Q_2;
    return r[DW-1:0];
  endfunction

`ifdef NTT_BF_HALF_EN
  function automatic logic [DW-1:0] mod_half(input logic [DW-1:0] x);
    logic [DW:0] s;
    s = {1'b0, x};
    if (x[0]) s = s + Q_1;
    return s[DW:1];
  endfunction
`endif

  // S1 registers
  logic          vld1;
  mode_e         mode1;
  logic [DW-1:0] u1, v1, w1, d1;
  // S2 registers
  logic          vld2;
  mode_e         mode2;
  logic [DW-1:0] u2, v2;
  logic [PW-1:0] p2;
  // S3 registers
  logic          vld3;
  mode_e         mode3;
  logic [DW-1:0] u3, v3, r3;
  // S4 registers
  logic          vld4;
  logic [DW-1:0] upper4, lower4;

  mode_e         mode_in;
  logic [DW-1:0] d_in;
  logic [DW-1:0] mul_a;
  logic [DW-1:0] upper_n, lower_n;

  assign mode_in = mode_e'(bus.mode);
  assign d_in    = (mode_in == MODE_GS) ? mod_sub(bus.u, bus.v) : '0;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mul_a = '0;
    case (mode1)
      MODE_CT: mul_a = v1;
      MODE_GS: mul_a = d1;
      default: mul_a = '0;
    endcase
  end

  always_comb begin
    upper_n = mod_sub(u3, v3);
    lower_n = mod_add(u3, v3);
    case (mode3)
      MODE_CT: begin
        upper_n = mod_add(u3, r3);
        lower_n = mod_sub(u3, r3);
      end
      MODE_GS: begin
`ifdef NTT_BF_HALF_EN
        upper_n = mod_half(mod_add(u3, v3));
        lower_n = mod_half(r3);
`else
        upper_n = mod_add(u3, v3);
        lower_n = r3;
`endif
      end
      default: ;
    endcase
  end

  // NOTE: the pipeline is a handful of flops, not a memory, so every stage is reset;
  // this keeps outputs X-free and drops in-flight work on reset.
  // NOTE: sequential state uses non-blocking assignment so all stages shift on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld1   <= 1'b0;  mode1 <= MODE_ADD;
      u1     <= '0;    v1    <= '0;  w1 <= '0;  d1 <= '0;
      vld2   <= 1'b0;  mode2 <= MODE_ADD;
      u2     <= '0;    v2    <= '0;  p2 <= '0;
      vld3   <= 1'b0;  mode3 <= MODE_ADD;
      u3     <= '0;    v3    <= '0;  r3 <= '0;
      vld4   <= 1'b0;
      upper4 <= '0;    lower4 <= '0;
    end else begin
      vld1   <= bus.valid_in;
      mode1  <= mode_in;
      u1     <= bus.u;
      v1     <= bus.v;
      w1     <= bus.w;
      d1     <= d_in;

      vld2   <= vld1;
      mode2  <= mode1;
      u2     <= u1;
      v2     <= v1;
      p2     <= PW'(mul_a) * PW'(w1);

      vld3   <= vld2;
      mode3  <= mode2;
      u3     <= u2;
      v3     <= v2;
      r3     <= barrett(p2);

      vld4   <= vld3;
      upper4 <= upper_n;
      lower4 <= lower_n;
    end
  end

  assign bus.valid_out = vld4;
  assign bus.bf_upper  = upper4;
  assign bus.bf_lower  = lower4;

endmodule

// File: tb/tb_ntt_bf_pe.sv
// Self-checking bench for ntt_bf_pe: directed table, random stream, reset mid-stream, Barrett sweep.
module tb_ntt_bf_pe;

  localparam int DW = 12;
  localparam int Q  = 3329;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ntt_bf_pe_if #(.DATA_WIDTH(DW)) bus ();

  ntt_bf_pe #(.DATA_WIDTH(DW), .MODULUS(Q)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [1:0] mode;
    int         u, v, w;
    int         eu, el;
  } vec_t;

  typedef struct {
    int eu, el;
    int due;
    int id;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   op_id    = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Reference: plain integer arithmetic; halving as multiplication by (Q+1)/2 = 2^-1 mod Q.
  function automatic void model(input int m, input int a, input int b, input int c,
                                output int up, output int lo);
    int t;
    case (m)
      1: begin
        t  = (b * c) % Q;
        up = (a + t) % Q;
        lo = (a - t + Q) % Q;
      end
      2: begin
        up = (a + b) % Q;
        lo = (((a - b + Q) % Q) * c) % Q;
`ifdef NTT_BF_HALF_EN
        up = (up * ((Q + 1) / 2)) % Q;
        lo = (lo * ((Q + 1) / 2)) % Q;
`endif
      end
      default: begin
        up = (a - b + Q) % Q;
        lo = (a + b) % Q;
      end
    endcase
  endfunction

  task automatic drive(input logic [1:0] m, input int a, input int b, input int c,
                       input int eu, input int el);
    exp_t e;
    @(posedge clk); #1;
    bus.valid_in = 1'b1;
    bus.mode     = m;
    bus.u        = 12'(a);
    bus.v        = 12'(b);
    bus.w        = 12'(c);
    e.eu = eu; e.el = el; e.due = cyc + 4; e.id = op_id;
    sb.push_back(e);
    op_id++;
  endtask

  task automatic drive_model(input logic [1:0] m, input int a, input int b, input int c);
    int eu, el;
    model(int'(m), a, b, c, eu, el);
    drive(m, a, b, c, eu, el);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  // Monitor: every valid output must match the oldest outstanding expectation, on time.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.valid_out) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check($sformatf("upper#%0d", e.id),   int'(bus.bf_upper), e.eu);
        check($sformatf("lower#%0d", e.id),   int'(bus.bf_lower), e.el);
        check($sformatf("latency#%0d", e.id), cyc, e.due);
      end
    end
  end

  vec_t vecs[9];

  initial begin
    vecs[0] = '{mode: 2'b00, u: 3328, v: 1,    w: 0,    eu: 3327, el: 0};
    vecs[1] = '{mode: 2'b01, u: 1,    v: 2,    w: 3,    eu: 7,    el: 3324};
    vecs[2] = '{mode: 2'b01, u: 3328, v: 3328, w: 3328, eu: 0,    el: 3327};
`ifdef NTT_BF_HALF_EN
    vecs[3] = '{mode: 2'b10, u: 5,    v: 10,   w: 2,    eu: 1672, el: 3324};
    vecs[4] = '{mode: 2'b10, u: 0,    v: 1,    w: 1,    eu: 1665, el: 1664};
`else
    vecs[3] = '{mode: 2'b10, u: 5,    v: 10,   w: 2,    eu: 15,   el: 3319};
    vecs[4] = '{mode: 2'b10, u: 0,    v: 1,    w: 1,    eu: 1,    el: 3328};
`endif
    vecs[5] = '{mode: 2'b11, u: 3328, v: 1,    w: 77,   eu: 3327, el: 0};
    vecs[6] = '{mode: 2'b00, u: 0,    v: 1,    w: 5,    eu: 3328, el: 1};
    vecs[7] = '{mode: 2'b01, u: 0,    v: 3328, w: 1,    eu: 3328, el: 1};
    vecs[8] = '{mode: 2'b00, u: 1664, v: 1665, w: 0,    eu: 3328, el: 0};

    rst = 1'b1;
    bus.valid_in = 1'b0; bus.mode = 2'b00; bus.u = '0; bus.v = '0; bus.w = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid_out", int'(bus.valid_out), 0);
    check("reset_bf_upper",  int'(bus.bf_upper),  0);
    check("reset_bf_lower",  int'(bus.bf_lower),  0);
    rst = 1'b0;
    idle(2);

    // Single isolated op: one-cycle valid pulse.
    drive(vecs[0].mode, vecs[0].u, vecs[0].v, vecs[0].w, vecs[0].eu, vecs[0].el);
    idle(8);

    // Directed table, back-to-back.
    for (int i = 0; i < 9; i++)
      drive(vecs[i].mode, vecs[i].u, vecs[i].v, vecs[i].w, vecs[i].eu, vecs[i].el);
    idle(8);

    // Random mixed-mode stream, 64 consecutive valid cycles.
    for (int i = 0; i < 64; i++)
      drive_model(2'($urandom_range(0, 3)), $urandom_range(0, Q - 1),
                  $urandom_range(0, Q - 1), $urandom_range(0, Q - 1));
    idle(8);
    drain();

    // Reset mid-cycle with operations in flight.
    for (int i = 0; i < 6; i++)
      drive_model(2'($urandom_range(0, 3)), $urandom_range(1, Q - 1),
                  $urandom_range(0, Q - 1), $urandom_range(1, Q - 1));
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valid_out", int'(bus.valid_out), 0);
    check("midrst_bf_upper",  int'(bus.bf_upper),  0);
    check("midrst_bf_lower",  int'(bus.bf_lower),  0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    idle(6);
    drive_model(2'b01, 1, 2, 3);
    idle(8);
    drain();

    // Barrett corner sweep: v in {0, 1, Q-1}, all w, CT mode.
    for (int k = 0; k < 3; k++) begin
      int vv;
      vv = (k == 0) ? 0 : (k == 1) ? 1 : Q - 1;
      for (int ww = 0; ww < Q; ww++)
        drive_model(2'b01, $urandom_range(0, Q - 1), vv, ww);
    end
    idle(8);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ntt_bf_pe.md
# ntt_bf_pe

Parametrised modular butterfly processing element for the NTT/INTT datapath. It replaces the fixed add/sub-only butterfly stage. It supports three modes:
- plain add/sub,
- Cooley-Tukey (CT) with twiddle multiply,
- Gentleman-Sande (GS) with twiddle multiply.

The modulus is a parameter, and modular reduction uses Barrett. The block is a fully pipelined, fixed-latency stream stage with a valid qualifier, sitting between the coefficient memory read port and the write-back path.

## Interface
- `DATA_WIDTH`, 12, coefficient width in bits.
- `MODULUS`, 3329, prime modulus Q. Must satisfy Q < 2^DATA_WIDTH.
- `BARRETT_M`, floor(2^(2*DATA_WIDTH)/MODULUS) (5039 for the defaults), Barrett constant.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset, asynchronous, active-high.
- `valid_in`  input  1  u/v/w/mode are valid this cycle.
- `mode`  input  2  00 add/sub, 01 CT, 10 GS, 11 reserved (behaves as 00).
- `u`, `v`  input  DATA_WIDTH  operands, each < Q.
- `w`  input  DATA_WIDTH  twiddle factor, < Q (ignored in mode 00).
- `valid_out`  output  1  `bf_upper`/`bf_lower` are valid.
- `bf_upper`, `bf_lower`  output  DATA_WIDTH  results, each in [0, Q).

## Operation
Functional results (all arithmetic mod Q):
- Mode 00: `bf_upper` = (u - v) mod Q, `bf_lower` = (u + v) mod Q.
- Mode 01 (CT): t = (v*w) mod Q; `bf_upper` = (u + t) mod Q, `bf_lower` = (u - t) mod Q.
- Mode 10 (GS): `bf_upper` = (u + v) mod Q, `bf_lower` = ((u - v)*w) mod Q.
- Mode 11: identical to mode 00.

Modular add and sub:
- Add: compute x+y at width DATA_WIDTH+1; subtract Q if the sum is >= Q.
- Sub: compute x-y; add Q if the result is negative.

Modular multiply:
- Form the full product a (2*DATA_WIDTH bits).
- q_est = (a*BARRETT_M) >> (2*DATA_WIDTH).
- r = a - q_est*Q, computed at width DATA_WIDTH+2.
- Apply up to two conditional subtractions of Q so that r < Q.

Pipeline stages, one register boundary each:
- S1: register inputs, mode and valid. In GS mode, also compute d = (u - v) mod Q.
- S2: register the product: v*w in CT mode, d*w in GS mode. Delay the unused operands.
- S3: register the Barrett-reduced product.
- S4: final add/sub (and halving, see Configuration); register the outputs and valid.

Mode and valid travel with their data. Mixing modes cycle-to-cycle is legal and requires no bubbles.

There is no backpressure. A new operation may be accepted every cycle.

The block does not check for inputs >= Q. Results for such inputs are undefined, and the bench must not drive them.

## Timing
- Latency: exactly 4 cycles from `valid_in` sampled high to `valid_out` high with the corresponding result. This holds for all modes, so mode 00 is padded through the multiplier stages.
- Throughput: 1 operation per cycle. Output order equals input order.
- `valid_out` is a pure delay of `valid_in`. Output data while `valid_out` = 0 is don't-care, but is not driven as X after reset.
- Reset values: `valid_out` = 0, `bf_upper` = 0, `bf_lower` = 0, and all pipeline registers are 0.
- Reset mid-stream: all in-flight operations are discarded. `valid_out` stays 0 until 4 cycles after the first `valid_in` sampled after `rst` deasserts.

## Configuration
- `NTT_BF_HALF_EN` defined: in mode 10 (GS) only, S4 multiplies both outputs by 2^-1 mod Q.
  - Halving rule: x even -> x/2; x odd -> (x+Q)/2.
  - Used for the INTT 1/N scaling. Latency is unchanged.
- Not defined: no halving. GS outputs are as listed in Operation.
- Modes 00 and 01 are unaffected either way.

## Test plan
- Mode 00, Q=3329: u=3328, v=1 -> 4 cycles later `bf_upper`=3327, `bf_lower`=0, `valid_out`=1 for one cycle.
- Mode 01: u=1, v=2, w=3 -> `bf_upper`=7, `bf_lower`=3324. Then u=v=w=3328 -> `bf_upper`=0, `bf_lower`=3327.
- Mode 10: u=5, v=10, w=2 -> `bf_upper`=15, `bf_lower`=3319. With `NTT_BF_HALF_EN` defined -> `bf_upper`=1672, `bf_lower`=3324.
- Back-to-back stream:
  - Stimulus: 64 consecutive valid cycles, random operands < Q, random modes.
  - Required response: outputs match the reference model in order, with a constant 4-cycle offset and no gaps in `valid_out`.
- Reset during stream:
  - Stimulus: assert `rst` asynchronously (mid-cycle) with 3 operations in flight.
  - Required response: `valid_out` and outputs go to 0 immediately. No stale result appears after release. The first post-reset operation emerges exactly 4 cycles after it is accepted.
- Barrett corner sweep: exhaustive v*w for v in {0, 1, Q-1} x all w < Q in CT mode -> every `bf_upper`/`bf_lower` is < Q and matches the model.
